// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select encoding and default fetch constants shared with decode.
package pc_pkg;
   typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET} pc_sel_t;
   localparam int DEF_INC = 4;
   localparam int DEF_OFFSET_SHIFT = 2;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; overwrites the oldest entry when full.
module ras_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wp, tp;
   logic [PW:0] count;
   assign tp = wp - 1'b1;
   assign top = mem[tp];
   assign empty = count == '0;
   assign full = count == (PW+1)'(DEPTH);
   // push together with pop replaces the top entry in place
   always_ff @(posedge clk)
      if (push) mem[pop ? tp : wp] <= data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         count <= '0;
      end else if (push && !pop) begin
         wp <= wp + 1'b1;
         if (!full) count <= count + 1'b1;
      end else if (pop && !push) begin
         wp <= tp;
         count <= count - 1'b1;
      end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: registered fetch PC with branch, jump, stall and return-address stack.
module pc_unit
   import pc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int INC = DEF_INC,
   parameter int OFFSET_SHIFT = DEF_OFFSET_SHIFT,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_offset,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus_inc,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_underflow
);
   logic [WIDTH-1:0] ras_top, pc_next;
   logic ret_ok;
   pc_sel_t sel;
   assign pc_plus_inc = pc + WIDTH'(INC);
   assign ret_ok = ret && !ras_empty;
   always_comb begin
      sel = ret_ok ? SEL_RET : jump ? SEL_JMP : branch_taken ? SEL_BR : SEL_SEQ;
      pc_next = sel == SEL_RET ? ras_top :
                sel == SEL_JMP ? jump_target :
                sel == SEL_BR  ? pc_plus_inc + (branch_offset << OFFSET_SHIFT) :
                                 pc_plus_inc;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc <= RESET_PC;
         ras_underflow <= 1'b0;
      end else if (!stall) begin
         pc <= pc_next;
         if (ret && ras_empty) ras_underflow <= 1'b1;
      end
   ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
      .clk(clk),
      .reset(reset),
      .push(call && !stall),
      .pop(ret_ok && !stall),
      .data(pc_plus_inc),
      .top(ras_top),
      .empty(ras_empty),
      .full(ras_full)
   );
endmodule
